// File: rtl/lutram_fifo_pkg.sv
// Shared constants, FSM encoding and level arithmetic for the 16-entry LUT-RAM FIFO.
// Optional almost flags are enabled in the top with LUTRAM_FIFO_ALMOST_EN.
package lutram_fifo_pkg;

    localparam int FIFO_DEPTH   = 16;
    localparam int FIFO_PTR_W   = 4;
    localparam int FIFO_LEVEL_W = 5;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

    // Occupancy after one edge; a simultaneous push and pop cancel out.
    function automatic logic [FIFO_LEVEL_W-1:0] level_step(
        input logic [FIFO_LEVEL_W-1:0] level,
        input logic                    push,
        input logic                    pop
    );
        logic [FIFO_LEVEL_W-1:0] result;
        result = level;
        if (push && !pop) begin
            result = level + 1'b1;
        end else if (pop && !push) begin
            result = level - 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lutram_fifo_mem.sv
// 16 x WIDTH storage built from one 16x1 dual-port LUT RAM per data bit.
// Includes a behavioural RAM16X1D with the vendor port names so the slice builds stand-alone.
module RAM16X1D (
    input  logic WCLK,
    input  logic WE,
    input  logic D,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic DPRA0,
    input  logic DPRA1,
    input  logic DPRA2,
    input  logic DPRA3,
    output logic SPO,
    output logic DPO
);

    // No reset: LUT RAM contents survive CLR.
    logic mem_reg [0:15];

    always_ff @(posedge WCLK) begin
        if (WE) begin
            mem_reg[{A3, A2, A1, A0}] <= D;
        end
    end

    assign SPO = mem_reg[{A3, A2, A1, A0}];
    assign DPO = mem_reg[{DPRA3, DPRA2, DPRA1, DPRA0}];

endmodule

module lutram_fifo_mem
    import lutram_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  WCLK,
    input  logic                  we,
    input  logic [FIFO_PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [FIFO_PTR_W-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] spo_unused;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            RAM16X1D u_ram (
                .WCLK  (WCLK),
                .WE    (we),
                .D     (wdata[gi]),
                .A0    (waddr[0]),
                .A1    (waddr[1]),
                .A2    (waddr[2]),
                .A3    (waddr[3]),
                .DPRA0 (raddr[0]),
                .DPRA1 (raddr[1]),
                .DPRA2 (raddr[2]),
                .DPRA3 (raddr[3]),
                .SPO   (spo_unused[gi]),
                .DPO   (rdata[gi])
            );
        end
    endgenerate

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// First-word-fall-through FIFO controller over a 16-entry LUT RAM, async CLR.
// Define LUTRAM_FIFO_ALMOST_EN to add registered almost_full / almost_empty outputs.
module lutram_fifo_ctrl
    import lutram_fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ALMOST = 2
) (
    input  logic                    WCLK,
    input  logic                    CLR,
    input  logic                    wr_valid,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    wr_ready,
    output logic                    rd_valid,
    output logic [WIDTH-1:0]        rd_data,
    input  logic                    rd_ready,
`ifdef LUTRAM_FIFO_ALMOST_EN
    output logic                    almost_full,
    output logic                    almost_empty,
`endif
    output logic [FIFO_LEVEL_W-1:0] level
);

    generate
        if (WIDTH < 1 || WIDTH > 32 || ALMOST < 1 || ALMOST > 8) begin : g_bad_param
            $error("lutram_fifo_ctrl: WIDTH must be 1..32 and ALMOST 1..8");
        end
    endgenerate

    fifo_state_t             state_reg, state_next;
    logic [FIFO_PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [FIFO_PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [FIFO_LEVEL_W-1:0] level_reg, level_next;
    logic                    push;
    logic                    pop;

    assign wr_ready = (state_reg != FULL);
    assign rd_valid = (state_reg != EMPTY);

    // The state register is already cleared while CLR is high, but the RAM write
    // enable is not, so the push term must be masked explicitly.
    assign push = wr_valid & wr_ready & ~CLR;
    assign pop  = rd_valid & rd_ready;

    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_step(level_reg, push, pop);

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        case (state_reg)
            EMPTY: begin
                if (push) begin
                    state_next = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop && level_reg == FIFO_LEVEL_W'(FIFO_DEPTH - 1)) begin
                    state_next = FULL;
                end else if (pop && !push && level_reg == FIFO_LEVEL_W'(1)) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next = PARTIAL;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge WCLK or posedge CLR) begin
        if (CLR) begin
            state_reg  <= EMPTY;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    assign level = level_reg;

`ifdef LUTRAM_FIFO_ALMOST_EN
    logic almost_full_reg, almost_full_next;
    logic almost_empty_reg, almost_empty_next;

    // Flags are computed from the post-edge level so they move with level itself.
    assign almost_full_next  = (level_next >= FIFO_LEVEL_W'(FIFO_DEPTH - ALMOST));
    assign almost_empty_next = (level_next <= FIFO_LEVEL_W'(ALMOST));

    always_ff @(posedge WCLK or posedge CLR) begin
        if (CLR) begin
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
        end else begin
            almost_full_reg  <= almost_full_next;
            almost_empty_reg <= almost_empty_next;
        end
    end

    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
`endif

    lutram_fifo_mem #(
        .WIDTH (WIDTH)
    ) u_mem (
        .WCLK  (WCLK),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (wr_data),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Directed self-checking bench for lutram_fifo_ctrl: vector table plus corner-case sequences.
// Almost-flag checks are included when LUTRAM_FIFO_ALMOST_EN is defined.
module tb_lutram_fifo_ctrl;

    logic       WCLK;
    logic       CLR;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [4:0] level;
`ifdef LUTRAM_FIFO_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    int errors = 0;
    int checks = 0;

    lutram_fifo_ctrl #(
        .WIDTH  (8),
        .ALMOST (2)
    ) dut (
        .WCLK         (WCLK),
        .CLR          (CLR),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
`ifdef LUTRAM_FIFO_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .level        (level)
    );

    initial WCLK = 1'b0;
    always #5 WCLK = ~WCLK;

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       exp_rv;
        logic [7:0] exp_rd;
        logic [4:0] exp_level;
        logic       exp_wr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge WCLK);
        #1;
    endtask

    task automatic chk_almost(input int lvl);
`ifdef LUTRAM_FIFO_ALMOST_EN
        chk($sformatf("almost_empty@%0d", lvl), {31'd0, almost_empty}, {31'd0, (lvl <= 2)});
        chk($sformatf("almost_full@%0d", lvl), {31'd0, almost_full}, {31'd0, (lvl >= 14)});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q [$];
        logic [7:0] d;

        //             wv  wd     rr   rv   rd     lvl   wr
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b1}; // first push
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b1}; // idle
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1}; // pop to empty
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b1}; // push+pop while empty
        vecs[4] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 5'd1, 1'b1}; // push+pop at 1
        vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 5'd2, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 5'd1, 1'b1};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1};

        CLR = 1'b1;
        wr_valid = 1'b0;
        wr_data = 8'h00;
        rd_ready = 1'b0;
        #2;
        chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset level", {27'd0, level}, 32'd0);
        chk("reset wr_ready", {31'd0, wr_ready}, 32'd1);
        chk_almost(0);
        cycle();
        CLR = 1'b0;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            rd_ready = vecs[i].rr;
            cycle();
            $display("vec %0d: wv=%0b wd=%02h rr=%0b -> rv=%0b rd=%02h lvl=%0d wr=%0b",
                     i, vecs[i].wv, vecs[i].wd, vecs[i].rr, rd_valid, rd_data, level, wr_ready);
            chk($sformatf("vec%0d rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].exp_rv});
            chk($sformatf("vec%0d level", i), {27'd0, level}, {27'd0, vecs[i].exp_level});
            chk($sformatf("vec%0d wr_ready", i), {31'd0, wr_ready}, {31'd0, vecs[i].exp_wr});
            if (vecs[i].exp_rv) begin
                chk($sformatf("vec%0d rd_data", i), {24'd0, rd_data}, {24'd0, vecs[i].exp_rd});
            end
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        // Fill to 16, overflow push, push+pop while FULL, drain in order
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            cycle();
            $display("fill push %02h -> level=%0d wr_ready=%0b", i, level, wr_ready);
            chk($sformatf("fill level %0d", i + 1), {27'd0, level}, 32'(i + 1));
            chk_almost(i + 1);
        end
        chk("full wr_ready", {31'd0, wr_ready}, 32'd0);
        wr_data = 8'hEE;
        cycle();
        $display("overflow push EE -> level=%0d", level);
        chk("overflow level", {27'd0, level}, 32'd16);
        chk("overflow head", {24'd0, rd_data}, 32'h00);
        wr_data  = 8'h77;
        rd_ready = 1'b1;
        cycle();
        $display("full push+pop 77 -> level=%0d wr_ready=%0b", level, wr_ready);
        chk("full pushpop level", {27'd0, level}, 32'd15);
        chk("full pushpop wr_ready", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain data %0d", i), {24'd0, rd_data}, 32'(i));
            cycle();
            $display("drain pop %02h -> level=%0d", i, level);
        end
        chk("drain level", {27'd0, level}, 32'd0);
        chk("drain rd_valid", {31'd0, rd_valid}, 32'd0);
        rd_ready = 1'b0;

        // Steady push+pop at level 5 across pointer wrap
        q.delete();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h40 + 8'(i);
            q.push_back(wr_data);
            cycle();
        end
        chk("steady prefill level", {27'd0, level}, 32'd5);
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'h45 + 8'(i);
            chk($sformatf("steady data %0d", i), {24'd0, rd_data}, {24'd0, q[0]});
            cycle();
            d = q.pop_front();
            q.push_back(wr_data);
            $display("steady %0d: popped %02h pushed %02h level=%0d", i, d, wr_data, level);
            chk($sformatf("steady level %0d", i), {27'd0, level}, 32'd5);
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("steady drain %0d", i), {24'd0, rd_data}, {24'd0, q[0]});
            d = q.pop_front();
            cycle();
        end
        chk("steady drain level", {27'd0, level}, 32'd0);
        rd_ready = 1'b0;

        // Asynchronous CLR mid-cycle at level 9
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h90 + 8'(i);
            cycle();
        end
        wr_valid = 1'b0;
        chk("preclr level", {27'd0, level}, 32'd9);
        #2;
        CLR = 1'b1;
        #1;
        $display("clr mid-cycle -> rv=%0b level=%0d wr_ready=%0b", rd_valid, level, wr_ready);
        chk("clr rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("clr level", {27'd0, level}, 32'd0);
        chk("clr wr_ready", {31'd0, wr_ready}, 32'd1);
        chk_almost(0);
        #2;
        CLR = 1'b0;
        cycle();
        chk("postclr level", {27'd0, level}, 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        cycle();
        wr_valid = 1'b0;
        $display("postclr push 5A -> rv=%0b rd=%02h level=%0d", rd_valid, rd_data, level);
        chk("postclr push level", {27'd0, level}, 32'd1);
        chk("postclr push rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("postclr push data", {24'd0, rd_data}, 32'h5A);
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        chk("postclr pop level", {27'd0, level}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
